// File: rtl/image_capture_sequencer.sv
// Image capture sequencer: triggers the camera, waits for a clean frame
// boundary, windows the incoming pixel stream to the configured line/pixel
// count and forwards the pixel MSBs to the flash write buffer.
module image_capture_sequencer #(
  parameter int PIX_W          = 12,
  parameter int OUT_W          = 8,
  parameter int CNT_W          = 12,
  parameter int TRIG_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             capture_start,
  input  logic             capture_abort,
  input  logic [CNT_W-1:0] cfg_num_lines,
  input  logic [CNT_W-1:0] cfg_num_pixels,
  input  logic             camera_FV,
  input  logic             camera_LV,
  input  logic             pixel_valid,
  input  logic [PIX_W-1:0] pixel_in,
  output logic             camera_trigger,
  output logic [OUT_W-1:0] pix_out,
  output logic             pix_out_valid,
  input  logic             pix_out_ready,
  output logic             busy,
  output logic             done,
  output logic [1:0]       error_code,
  output logic [CNT_W-1:0] line_count
);

  // One counter times both the trigger pulse and the frame-start timeout,
  // so it must hold the larger of the two limits.
  localparam int TMO_MAX = (TIMEOUT_CYCLES > TRIG_CYCLES) ? TIMEOUT_CYCLES : TRIG_CYCLES;
  localparam int TMO_W   = $clog2(TMO_MAX + 1);

  typedef enum logic [2:0] {
    IDLE, TRIGGER, WAIT_FV_LOW, WAIT_FV_HIGH, WAIT_LV, LINE, DONE, ERR
  } state_t;

  state_t             state_q, state_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [CNT_W-1:0]   pixCnt_q, pixCnt_d;
  logic [CNT_W-1:0]   lineCnt_q, lineCnt_d;
  logic [CNT_W-1:0]   linesCfg_q, linesCfg_d;
  logic [CNT_W-1:0]   pixelsCfg_q, pixelsCfg_d;
  logic [1:0]         err_q, err_d;
  logic [OUT_W-1:0]   pix_q;
  logic               pixVld_q;
  logic               pixAccept;
  logic               abortNow;
  logic               tmoHit;
  logic               unusedPixBits;

  // Only the pixel MSBs are forwarded; the reduction keeps the LSBs referenced.
  assign unusedPixBits = ^pixel_in;

  assign abortNow = capture_abort && (state_q != IDLE);
  assign tmoHit   = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  assign camera_trigger = (state_q == TRIGGER);
  assign busy           = (state_q != IDLE);
  assign done           = (state_q == DONE) || (state_q == ERR);
  assign error_code     = err_q;
  assign line_count     = lineCnt_q;
  assign pix_out        = pix_q;
  assign pix_out_valid  = pixVld_q;

  // Sequencer state, counters, latched configuration and error code.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      tmo_q       <= '0;
      pixCnt_q    <= '0;
      lineCnt_q   <= '0;
      linesCfg_q  <= '0;
      pixelsCfg_q <= '0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      pixCnt_q    <= pixCnt_d;
      lineCnt_q   <= lineCnt_d;
      linesCfg_q  <= linesCfg_d;
      pixelsCfg_q <= pixelsCfg_d;
      err_q       <= err_d;
    end
  end

  // Next-state logic; abort overrides every other transition.
  always_comb begin
    state_d     = state_q;
    tmo_d       = tmo_q;
    pixCnt_d    = pixCnt_q;
    lineCnt_d   = lineCnt_q;
    linesCfg_d  = linesCfg_q;
    pixelsCfg_d = pixelsCfg_q;
    err_d       = err_q;
    pixAccept   = 1'b0;
    if (abortNow) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (capture_start) begin
            linesCfg_d  = cfg_num_lines;
            pixelsCfg_d = cfg_num_pixels;
            err_d       = 2'd0;
            lineCnt_d   = '0;
            tmo_d       = '0;
            if ((cfg_num_lines == '0) || (cfg_num_pixels == '0)) state_d = DONE;
            else                                                  state_d = TRIGGER;
          end
        end
        TRIGGER: begin
          tmo_d = tmo_q + TMO_W'(1);
          if (tmoHit) begin
            state_d = ERR;
            err_d   = 2'd1;
          end else if (tmo_q == TMO_W'(TRIG_CYCLES - 1)) begin
            state_d = WAIT_FV_LOW;
          end
        end
        WAIT_FV_LOW: begin
          tmo_d = tmo_q + TMO_W'(1);
          if (tmoHit) begin
            state_d = ERR;
            err_d   = 2'd1;
          end else if (!camera_FV) begin
            state_d = WAIT_FV_HIGH;
          end
        end
        WAIT_FV_HIGH: begin
          tmo_d = tmo_q + TMO_W'(1);
          if (tmoHit) begin
            state_d = ERR;
            err_d   = 2'd1;
          end else if (camera_FV) begin
            state_d = WAIT_LV;
          end
        end
        WAIT_LV: begin
          if (camera_LV) begin
            state_d  = LINE;
            pixCnt_d = '0;
          end else if (!camera_FV) begin
            state_d = ERR;
            err_d   = 2'd2;
          end
        end
        LINE: begin
          if (camera_LV) begin
            if (pixel_valid && (pixCnt_q < pixelsCfg_q)) begin
              if (pixVld_q && !pix_out_ready) begin
                state_d = ERR;
                err_d   = 2'd3;
              end else begin
                pixAccept = 1'b1;
                pixCnt_d  = pixCnt_q + CNT_W'(1);
              end
            end
          end else if (pixCnt_q < pixelsCfg_q) begin
            state_d = ERR;
            err_d   = 2'd2;
          end else begin
            lineCnt_d = lineCnt_q + CNT_W'(1);
            if ((lineCnt_q + CNT_W'(1)) == linesCfg_q) state_d = DONE;
            else                                       state_d = WAIT_LV;
          end
        end
        DONE, ERR: state_d = IDLE;
        default:   state_d = IDLE;
      endcase
    end
  end

  // Single-entry output buffer: a new pixel may load in the same cycle the
  // previous one is handed off, otherwise a handshake empties it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_q    <= '0;
      pixVld_q <= 1'b0;
    end else if (abortNow) begin
      pixVld_q <= 1'b0;
    end else if (pixAccept) begin
      pix_q    <= pixel_in[PIX_W-1 -: OUT_W];
      pixVld_q <= 1'b1;
    end else if (pix_out_ready) begin
      pixVld_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_image_capture_sequencer.sv
// Bench for image_capture_sequencer: table of capture scenarios (fixed and
// randomized) compared against a frame-level reference model, plus hand
// sequences for timeout, overflow, abort and asynchronous reset.
module tb_image_capture_sequencer;

  localparam int PIX_W = 12;
  localparam int OUT_W = 8;
  localparam int CNT_W = 12;
  localparam int TRIG  = 16;
  localparam int TMO   = 100;

  logic             clk = 1'b0;
  logic             reset;
  logic             capture_start, capture_abort;
  logic [CNT_W-1:0] cfg_num_lines, cfg_num_pixels;
  logic             camera_FV, camera_LV, pixel_valid;
  logic [PIX_W-1:0] pixel_in;
  logic             camera_trigger;
  logic [OUT_W-1:0] pix_out;
  logic             pix_out_valid, pix_out_ready;
  logic             busy, done;
  logic [1:0]       error_code;
  logic [CNT_W-1:0] line_count;

  typedef struct {
    int cfgLines;
    int cfgPix;
    int senLines;
    int senPix;
    int shortIdx;
    int shortLen;
    int midFrame;
    int expErr;
    int expLines;
  } vec_t;

  vec_t vecs[12];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int doneCount = 0;
  int trigCount = 0;
  int doneCycle = 0;
  logic [1:0]       doneErr;
  logic [CNT_W-1:0] doneLines;
  logic [OUT_W-1:0] gotQ[$];
  logic [OUT_W-1:0] expQ[$];
  int doneBase, trigBase, gotBase, startCyc;

  image_capture_sequencer #(
    .PIX_W(PIX_W), .OUT_W(OUT_W), .CNT_W(CNT_W),
    .TRIG_CYCLES(TRIG), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .capture_start(capture_start), .capture_abort(capture_abort),
    .cfg_num_lines(cfg_num_lines), .cfg_num_pixels(cfg_num_pixels),
    .camera_FV(camera_FV), .camera_LV(camera_LV),
    .pixel_valid(pixel_valid), .pixel_in(pixel_in),
    .camera_trigger(camera_trigger),
    .pix_out(pix_out), .pix_out_valid(pix_out_valid), .pix_out_ready(pix_out_ready),
    .busy(busy), .done(done), .error_code(error_code), .line_count(line_count)
  );

  // Free-running clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Observe done pulses, trigger width and handed-off beats mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (done) begin
        doneCount++;
        doneErr   = error_code;
        doneLines = line_count;
        doneCycle = cyc;
      end
      if (camera_trigger) trigCount++;
      if (pix_out_valid && pix_out_ready) gotQ.push_back(pix_out);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic int lineLen(input vec_t v, input int l);
    return (l == v.shortIdx) ? v.shortLen : v.senPix;
  endfunction

  // Frame-level reference: how many sensor lines get forwarded and how the
  // capture ends, from the windowing and short-frame/short-line rules.
  function automatic void modelCapture(input vec_t v, output int expErr, output int expLines, output int fwdLines);
    int lim;
    if (v.cfgLines == 0 || v.cfgPix == 0) begin
      expErr = 0; expLines = 0; fwdLines = 0;
      return;
    end
    lim = (v.cfgLines < v.senLines) ? v.cfgLines : v.senLines;
    for (int l = 0; l < lim; l++) begin
      if (lineLen(v, l) < v.cfgPix) begin
        expErr = 2; expLines = l; fwdLines = l + 1;
        return;
      end
    end
    if (v.senLines < v.cfgLines) begin
      expErr = 2; expLines = v.senLines; fwdLines = v.senLines;
    end else begin
      expErr = 0; expLines = v.cfgLines; fwdLines = v.cfgLines;
    end
  endfunction

  task automatic startCapture(input int cl, input int cp, input logic fv);
    expQ.delete();
    doneBase = doneCount;
    trigBase = trigCount;
    gotBase  = gotQ.size();
    camera_FV      = fv;
    cfg_num_lines  = CNT_W'(cl);
    cfg_num_pixels = CNT_W'(cp);
    tick();
    capture_start = 1'b1;
    startCyc = cyc;
    tick();
    capture_start = 1'b0;
  endtask

  task automatic interrupt(input int kind);
    if (kind == 1) begin
      capture_abort = 1'b1;
      tick();
      capture_abort = 1'b0;
      checkOutput("abort busy", busy, 0);
      checkOutput("abort pix_out_valid", pix_out_valid, 0);
      checkOutput("abort camera_trigger", camera_trigger, 0);
    end else begin
      #2 reset = 1'b1;
      #1;
      checkOutput("async reset busy", busy, 0);
      checkOutput("async reset done", done, 0);
      checkOutput("async reset pix_out_valid", pix_out_valid, 0);
      checkOutput("async reset pix_out", pix_out, 0);
      checkOutput("async reset line_count", line_count, 0);
      checkOutput("async reset error_code", error_code, 0);
      checkOutput("async reset camera_trigger", camera_trigger, 0);
      #2 reset = 1'b0;
    end
  endtask

  // Sensor model: optional partial frame already in progress, then a frame
  // of lines with randomly spaced pixels and random data.
  task automatic sendFrame(input vec_t v, input int fwdLines, input int intAt, input int intKind);
    int idx = 0;
    if (v.senLines == 0) begin
      repeat (6) tick();
      return;
    end
    if (v.midFrame != 0) begin
      camera_LV = 1'b1;
      repeat (10) begin
        pixel_valid = 1'b1;
        pixel_in    = PIX_W'($urandom);
        tick();
        pixel_valid = 1'b0;
      end
      camera_LV = 1'b0;
      repeat (10) tick();
      camera_FV = 1'b0;
      repeat (4) tick();
    end else begin
      repeat (22) tick();
    end
    camera_FV = 1'b1;
    repeat (2) tick();
    for (int l = 0; l < v.senLines; l++) begin
      camera_LV = 1'b1;
      tick();
      for (int p = 0; p < lineLen(v, l); p++) begin
        pixel_in    = PIX_W'($urandom);
        pixel_valid = 1'b1;
        if (l < fwdLines && p < v.cfgPix) expQ.push_back(pixel_in[PIX_W-1 -: OUT_W]);
        tick();
        pixel_valid = 1'b0;
        if (idx == intAt) interrupt(intKind);
        idx++;
        if ($urandom_range(0, 2) == 0) tick();
      end
      camera_LV = 1'b0;
      repeat (3) tick();
    end
    camera_FV = 1'b0;
    repeat (3) tick();
  endtask

  task automatic waitDone(input int budget);
    for (int i = 0; i < budget && doneCount == doneBase; i++) tick();
  endtask

  task automatic applyStimulus(input vec_t v, input int intAt, input int intKind);
    int e, l, f;
    modelCapture(v, e, l, f);
    startCapture(v.cfgLines, v.cfgPix, v.midFrame != 0);
    sendFrame(v, f, intAt, intKind);
    if (intKind == 0) waitDone(30);
    repeat (2) tick();
  endtask

  task automatic checkCapture(input string tag, input vec_t v);
    int nGot;
    logic zeroCfg;
    zeroCfg = (v.cfgLines == 0 || v.cfgPix == 0);
    nGot = gotQ.size() - gotBase;
    checkOutput($sformatf("%s done pulses", tag), doneCount - doneBase, 1);
    checkOutput($sformatf("%s error_code at done", tag), doneErr, v.expErr);
    checkOutput($sformatf("%s line_count at done", tag), doneLines, v.expLines);
    checkOutput($sformatf("%s trigger cycles", tag), trigCount - trigBase, zeroCfg ? 0 : TRIG);
    checkOutput($sformatf("%s beat count", tag), nGot, expQ.size());
    for (int j = 0; j < expQ.size(); j++)
      if (j < nGot) checkOutput($sformatf("%s beat %0d", tag, j), gotQ[gotBase + j], expQ[j]);
    checkOutput($sformatf("%s busy after done", tag), busy, 0);
    checkOutput($sformatf("%s error_code held", tag), error_code, v.expErr);
    if (zeroCfg) checkOutput($sformatf("%s done latency", tag), doneCycle - startCyc, 1);
  endtask

  initial begin
    int e, l, f, lat;
    vec_t v;
    reset = 1'b1;
    capture_start = 1'b0; capture_abort = 1'b0;
    cfg_num_lines = '0; cfg_num_pixels = '0;
    camera_FV = 1'b0; camera_LV = 1'b0; pixel_valid = 1'b0; pixel_in = '0;
    pix_out_ready = 1'b1;

    vecs[0] = '{5, 40, 5, 40, -1, 0, 0, 0, 5};
    vecs[1] = '{3, 8, 3, 8, -1, 0, 1, 0, 3};
    vecs[2] = '{2, 10, 5, 40, -1, 0, 0, 0, 2};
    vecs[3] = '{2, 40, 2, 40, 1, 30, 0, 2, 1};
    vecs[4] = '{4, 6, 2, 6, -1, 0, 0, 2, 2};
    vecs[5] = '{1, 1, 2, 3, -1, 0, 0, 0, 1};
    vecs[6] = '{0, 5, 0, 0, -1, 0, 0, 0, 0};
    vecs[7] = '{3, 0, 0, 0, -1, 0, 0, 0, 0};
    for (int i = 8; i < 12; i++) begin
      vecs[i].cfgLines = $urandom_range(1, 3);
      vecs[i].cfgPix   = $urandom_range(1, 10);
      vecs[i].senLines = $urandom_range(1, 4);
      vecs[i].senPix   = $urandom_range(1, 12);
      vecs[i].shortIdx = ($urandom_range(0, 1) == 1) ? $urandom_range(0, vecs[i].senLines - 1) : -1;
      vecs[i].shortLen = $urandom_range(0, vecs[i].senPix);
      vecs[i].midFrame = $urandom_range(0, 1);
      modelCapture(vecs[i], e, l, f);
      vecs[i].expErr   = e;
      vecs[i].expLines = l;
    end

    repeat (3) tick();
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset camera_trigger", camera_trigger, 0);
    checkOutput("reset pix_out_valid", pix_out_valid, 0);
    checkOutput("reset pix_out", pix_out, 0);
    checkOutput("reset error_code", error_code, 0);
    checkOutput("reset line_count", line_count, 0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i], -1, 0);
      checkCapture($sformatf("vec%0d", i), vecs[i]);
    end

    $display("[TB] frame-start timeout");
    startCapture(2, 5, 1'b0);
    waitDone(200);
    lat = doneCycle - startCyc;
    checkOutput("timeout done pulses", doneCount - doneBase, 1);
    checkOutput("timeout error_code", doneErr, 1);
    checkOutput("timeout latency within 100..102", (lat >= 100 && lat <= 102), 1);
    checkOutput("timeout trigger cycles", trigCount - trigBase, TRIG);
    checkOutput("timeout line_count", doneLines, 0);
    repeat (2) tick();

    $display("[TB] output overflow");
    pix_out_ready = 1'b0;
    v = '{1, 4, 1, 4, -1, 0, 0, 3, 0};
    applyStimulus(v, -1, 0);
    checkOutput("overflow done pulses", doneCount - doneBase, 1);
    checkOutput("overflow error_code", doneErr, 3);
    checkOutput("overflow line_count", doneLines, 0);
    checkOutput("overflow pix_out holds first pixel", pix_out, expQ[0]);
    pix_out_ready = 1'b1;
    repeat (3) tick();

    $display("[TB] abort mid-line");
    v = '{3, 20, 3, 20, -1, 0, 0, 0, 0};
    applyStimulus(v, 5, 1);
    repeat (10) tick();
    checkOutput("abort no done pulse", doneCount - doneBase, 0);
    checkOutput("abort error_code", error_code, 0);
    checkOutput("abort idle busy", busy, 0);

    $display("[TB] asynchronous reset mid-line");
    v = '{2, 10, 2, 10, -1, 0, 0, 0, 0};
    applyStimulus(v, 13, 2);
    checkOutput("reset capture no done", doneCount - doneBase, 0);
    applyStimulus(vecs[0], -1, 0);
    checkCapture("post-reset nominal", vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
